pattern_detect_param: RTL

Parametrised serial pattern detector that generalises the fixed two-state "01" sequence counter. It takes a qualified serial bit stream and a run-time loadable PAT_W-bit pattern, and runs in overlapping or non-overlapping match mode. It produces a registered one-cycle match pulse plus a saturating match counter with a sticky saturation flag. It sits between a serial input source and the testbench or monitor logic in the same single-clock domain.

---
 rtl/pattern_detect_param.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pattern_detect_param.sv
// -----------------------------------------------------------------------------
// pattern_detect_param
//   Serial pattern detector with a run-time loadable PAT_W-bit pattern. It
//   supports overlapping and non-overlapping matching, drives a registered
//   one-cycle match pulse, and keeps a saturating match counter with a sticky
//   saturation flag.
//
// Parameters
//   PAT_W     pattern length in bits (2..16)
//   CNT_W     match counter width (>= 1)
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   x_i       serial data bit
//   valid_i   qualifies x_i; history shifts only when high
//   load_i    latch pattern_i, clear history, start detection
//   pattern_i pattern to load; bit PAT_W-1 is the first bit received
//   overlap_i 1 = overlapping matches, 0 = non-overlapping
//   clr_cnt_i synchronous clear of count_o and sat_o
//   z_o       registered one-cycle match pulse
//   count_o   saturating match count
//   sat_o     sticky; set when count_o reaches 2^CNT_W-1
//   busy_o    high whenever the detector is not idle
// -----------------------------------------------------------------------------
module pattern_detect_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_i,
    input  logic             valid_i,
    input  logic             load_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic             overlap_i,
    input  logic             clr_cnt_i,
    output logic             z_o,
    output logic [CNT_W-1:0] count_o,
    output logic             sat_o,
    output logic             busy_o
);

    localparam int FILL_W = $clog2(PAT_W);
    // The last fill value seen in FILL. The next valid bit completes the
    // history and moves the detector to RUN.
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 2);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } state_e;

    state_e              state_q, state_d;
    logic [PAT_W-1:0]    pat_q, pat_d;
    logic [PAT_W-2:0]    hist_q, hist_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                z_q, z_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                sat_q, sat_d;

    logic [PAT_W-1:0]    cand;
    logic                match;

    // Candidate word: the stored history followed by the incoming bit.
    // Its low PAT_W-1 bits also form the shifted history. Taking the shift
    // from cand means PAT_W=2 needs no special case.
    assign cand = {hist_q, x_i};

    // NOTE: combinational next-state logic gives every output a default
    // first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        count_d = count_q;
        sat_d   = sat_q;
        match   = 1'b0;

        if (load_i) begin
            // load takes priority. x_i is ignored in this cycle.
            pat_d   = pattern_i;
            hist_d  = '0;
            fill_d  = '0;
            state_d = FILL;
        end else if (valid_i) begin
            unique case (state_q)
                FILL: begin
                    hist_d = cand[PAT_W-2:0];
                    fill_d = fill_q + 1'b1;
                    if (fill_q == FILL_LAST) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    match = (cand == pat_q);
                    if (match && !overlap_i) begin
                        // Non-overlapping: the next match needs PAT_W fresh bits.
                        hist_d  = '0;
                        fill_d  = '0;
                        state_d = FILL;
                    end else begin
                        hist_d = cand[PAT_W-2:0];
                    end
                end
                default: ;
            endcase
        end

        z_d = match;

        // A clear wins over a coincident increment. z_o still pulses.
        if (clr_cnt_i) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (match && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
            if (count_q == CNT_MAX - 1'b1) begin
                sat_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            z_q     <= 1'b0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            z_q     <= z_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign z_o     = z_q;
    assign count_o = count_q;
    assign sat_o   = sat_q;
    assign busy_o  = (state_q != IDLE);

endmodule
